universal_shift_reg: RTL and testbench

Parametrised universal shift register for the UART datapath. It provides per-cycle hold, shift, rotate, parallel-load and synchronous-clear modes over a WIDTH-bit register. An optional burst engine performs a counted sequence of serial shifts and flags completion. TX/RX framing logic uses it to serialise and deserialise characters without an external bit counter.

---
 rtl/universal_shift_reg.sv | 138 +++++++++++++
 tb/tb_universal_shift_reg.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold/shift/rotate/load/clear plus optional burst engine.
// Define USR_BURST_EN to compile in the counted-shift burst engine (busy/done).
module universal_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sr_inRS,
  input  logic             sr_inLS,
  input  logic             start,
  input  logic [CW-1:0]    burst_len,
  input  logic             dir,
  output logic [WIDTH-1:0] q,
  output logic             sr_outRS,
  output logic             sr_outLS,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] shr;
  logic [WIDTH-1:0] shl;
  logic [WIDTH-1:0] mode_q;

  assign shr = {sr_inRS, q_r[WIDTH-1:1]};
  assign shl = {q_r[WIDTH-2:0], sr_inLS};

  always_comb begin
    mode_q = q_r;
    unique case (mode)
      3'b000: mode_q = q_r;
      3'b001: mode_q = shr;
      3'b010: mode_q = shl;
      3'b011: mode_q = d;
      3'b100: mode_q = {q_r[0], q_r[WIDTH-1:1]};
      3'b101: mode_q = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
      3'b110: mode_q = {q_r[WIDTH-1], q_r[WIDTH-1:1]};
      3'b111: mode_q = '0;
    endcase
  end

  assign q        = q_r;
  assign sr_outRS = q_r[0];
  assign sr_outLS = q_r[WIDTH-1];

`ifdef USR_BURST_EN

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW-1:0] MAX = CW'(WIDTH);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] q_nx;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nx;
  logic [CW-1:0]    len_sat;
  logic             bdir;
  logic             bdir_nx;
  logic             done_r;
  logic             done_nx;

  assign len_sat = (burst_len > MAX) ? MAX : burst_len;

  // done is a pure one-cycle pulse: it defaults low every edge, en or not
  always_comb begin
    state_nx = state;
    q_nx     = q_r;
    cnt_nx   = cnt;
    bdir_nx  = bdir;
    done_nx  = 1'b0;
    if (en) begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            cnt_nx  = len_sat;
            bdir_nx = dir;
            if (len_sat == '0) done_nx  = 1'b1;
            else               state_nx = S_RUN;
          end else begin
            q_nx = mode_q;
          end
        end
        S_RUN: begin
          q_nx   = bdir ? shl : shr;
          cnt_nx = cnt - ONE;
          if (cnt == ONE) begin
            state_nx = S_IDLE;
            done_nx  = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state  <= S_IDLE;
      q_r    <= '0;
      cnt    <= '0;
      bdir   <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state  <= state_nx;
      q_r    <= q_nx;
      cnt    <= cnt_nx;
      bdir   <= bdir_nx;
      done_r <= done_nx;
    end
  end

  assign busy = (state == S_RUN);
  assign done = done_r;

`else

  logic unused_burst;
  assign unused_burst = ^{start, burst_len, dir};

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) q_r <= '0;
    else if (en)  q_r <= mode_q;
  end

  assign busy = 1'b0;
  assign done = 1'b0;

`endif

endmodule

// File: tb/tb_universal_shift_reg.sv
// Self-checking bench for universal_shift_reg (WIDTH=8): vector table plus burst sequences.
module tb_universal_shift_reg;

  localparam int W  = 8;
  localparam int CW = $clog2(W+1);

  logic          clk;
  logic          clear_n;
  logic          en;
  logic [2:0]    mode;
  logic [W-1:0]  d;
  logic          sr_inRS;
  logic          sr_inLS;
  logic          start;
  logic [CW-1:0] burst_len;
  logic          dir;
  logic [W-1:0]  q;
  logic          sr_outRS;
  logic          sr_outLS;
  logic          busy;
  logic          done;

  universal_shift_reg #(.WIDTH(W)) dut (
    .clk      (clk),
    .clear_n  (clear_n),
    .en       (en),
    .mode     (mode),
    .d        (d),
    .sr_inRS  (sr_inRS),
    .sr_inLS  (sr_inLS),
    .start    (start),
    .burst_len(burst_len),
    .dir      (dir),
    .q        (q),
    .sr_outRS (sr_outRS),
    .sr_outLS (sr_outLS),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] q;
    logic       busy;
    logic       done;
  } exp_t;

  typedef struct {
    string      name;
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       rs;
    logic       ls;
    logic [7:0] exp_q;
  } vec_t;

  exp_t sb[$];
  vec_t vt[20];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [7:0] m;

  task automatic check_out();
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: no expected entry queued");
      return;
    end
    e = sb.pop_front();
    if (q !== e.q || busy !== e.busy || done !== e.done ||
        sr_outRS !== e.q[0] || sr_outLS !== e.q[7]) begin
      n_fail++;
      $display("FAIL %s: got q=%h busy=%b done=%b outRS=%b outLS=%b, need q=%h busy=%b done=%b",
               e.name, q, busy, done, sr_outRS, sr_outLS, e.q, e.busy, e.done);
    end
  endtask

  task automatic cyc(input string nm, input logic [7:0] eq,
                     input logic eb, input logic ed);
    exp_t e;
    e.name = nm;
    e.q    = eq;
    e.busy = eb;
    e.done = ed;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic check_now(input string nm, input logic [7:0] eq,
                           input logic eb, input logic ed);
    exp_t e;
    e.name = nm;
    e.q    = eq;
    e.busy = eb;
    e.done = ed;
    sb.push_back(e);
    check_out();
  endtask

  initial begin
    vt[0]  = '{"load_a5",  1'b1, 3'b011, 8'hA5, 1'b0, 1'b0, 8'hA5};
    vt[1]  = '{"shr_rs1",  1'b1, 3'b001, 8'h00, 1'b1, 1'b0, 8'hD2};
    vt[2]  = '{"rotl",     1'b1, 3'b101, 8'h00, 1'b0, 1'b0, 8'hA5};
    vt[3]  = '{"asr_neg",  1'b1, 3'b110, 8'h00, 1'b0, 1'b0, 8'hD2};
    vt[4]  = '{"shl_ls0",  1'b1, 3'b010, 8'h00, 1'b0, 1'b0, 8'hA4};
    vt[5]  = '{"load_3c",  1'b1, 3'b011, 8'h3C, 1'b0, 1'b0, 8'h3C};
    vt[6]  = '{"en0_a",    1'b0, 3'b001, 8'h00, 1'b1, 1'b0, 8'h3C};
    vt[7]  = '{"en0_b",    1'b0, 3'b001, 8'h00, 1'b1, 1'b0, 8'h3C};
    vt[8]  = '{"en0_c",    1'b0, 3'b001, 8'h00, 1'b1, 1'b0, 8'h3C};
    vt[9]  = '{"en1_shr",  1'b1, 3'b001, 8'h00, 1'b0, 1'b0, 8'h1E};
    vt[10] = '{"rotr_1e",  1'b1, 3'b100, 8'h00, 1'b0, 1'b0, 8'h0F};
    vt[11] = '{"sclr",     1'b1, 3'b111, 8'hFF, 1'b1, 1'b1, 8'h00};
    vt[12] = '{"load_81",  1'b1, 3'b011, 8'h81, 1'b0, 1'b0, 8'h81};
    vt[13] = '{"hold",     1'b1, 3'b000, 8'hFF, 1'b1, 1'b1, 8'h81};
    vt[14] = '{"rotr_81",  1'b1, 3'b100, 8'h00, 1'b0, 1'b0, 8'hC0};
    vt[15] = '{"shr_rs0",  1'b1, 3'b001, 8'h00, 1'b0, 1'b1, 8'h60};
    vt[16] = '{"shl_ls1",  1'b1, 3'b010, 8'h00, 1'b0, 1'b1, 8'hC1};
    vt[17] = '{"asr_c1",   1'b1, 3'b110, 8'h00, 1'b0, 1'b0, 8'hE0};
    vt[18] = '{"rotl_e0",  1'b1, 3'b101, 8'h00, 1'b0, 1'b0, 8'hC1};
    vt[19] = '{"en0_load", 1'b0, 3'b011, 8'hFF, 1'b0, 1'b0, 8'hC1};

    clear_n   = 1'b1;
    en        = 1'b0;
    mode      = 3'b000;
    d         = 8'h00;
    sr_inRS   = 1'b0;
    sr_inLS   = 1'b0;
    start     = 1'b0;
    burst_len = '0;
    dir       = 1'b0;

    repeat (2) @(posedge clk);
    #3 clear_n = 1'b0;
    #1 check_now("async_reset", 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    clear_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      en      = vt[i].en;
      mode    = vt[i].mode;
      d       = vt[i].d;
      sr_inRS = vt[i].rs;
      sr_inLS = vt[i].ls;
      cyc(vt[i].name, vt[i].exp_q, 1'b0, 1'b0);
    end

`ifdef USR_BURST_EN
    en   = 1'b1;
    mode = 3'b011;
    d    = 8'h96;
    cyc("load_96", 8'h96, 1'b0, 1'b0);

    m         = 8'h96;
    mode      = 3'b000;
    start     = 1'b1;
    burst_len = CW'(8);
    dir       = 1'b0;
    sr_inRS   = 1'b0;
    cyc("burst_accept", m, 1'b1, 1'b0);
    start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k == 4) begin
        mode  = 3'b011;
        d     = 8'hFF;
        start = 1'b1;
      end
      if (k == 8) begin
        start     = 1'b1;
        burst_len = CW'(3);
        dir       = 1'b1;
        sr_inLS   = 1'b1;
      end
      m = {sr_inRS, m[7:1]};
      cyc($sformatf("burst_shift%0d", k), m, k < 8, k == 8);
    end

    cyc("reaccept", 8'h00, 1'b1, 1'b0);
    start = 1'b0;
    en    = 1'b0;
    cyc("b_en0_hold", 8'h00, 1'b1, 1'b0);
    en = 1'b1;
    cyc("b_shl1", 8'h01, 1'b1, 1'b0);
    cyc("b_shl2", 8'h03, 1'b1, 1'b0);
    cyc("b_shl3", 8'h07, 1'b0, 1'b1);
    en = 1'b0;
    cyc("done_clr_en0", 8'h07, 1'b0, 1'b0);

    en        = 1'b1;
    mode      = 3'b000;
    start     = 1'b1;
    burst_len = '0;
    cyc("len0_done", 8'h07, 1'b0, 1'b1);
    start = 1'b0;
    cyc("len0_after", 8'h07, 1'b0, 1'b0);

    m         = 8'h07;
    start     = 1'b1;
    burst_len = '1;
    dir       = 1'b0;
    sr_inRS   = 1'b1;
    cyc("sat_accept", m, 1'b1, 1'b0);
    start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      m = {sr_inRS, m[7:1]};
      cyc($sformatf("sat_shift%0d", k), m, k < 8, k == 8);
    end
    cyc("sat_after", 8'hFF, 1'b0, 1'b0);

    mode = 3'b011;
    d    = 8'h96;
    cyc("abort_load", 8'h96, 1'b0, 1'b0);
    m         = 8'h96;
    mode      = 3'b000;
    start     = 1'b1;
    burst_len = CW'(8);
    dir       = 1'b0;
    sr_inRS   = 1'b0;
    cyc("abort_accept", m, 1'b1, 1'b0);
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      m = {1'b0, m[7:1]};
      cyc($sformatf("abort_shift%0d", k), m, 1'b1, 1'b0);
    end
    @(negedge clk);
    clear_n = 1'b0;
    #1 check_now("abort_reset", 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    clear_n = 1'b1;
    for (int k = 0; k < 10; k++)
      cyc($sformatf("abort_quiet%0d", k), 8'h00, 1'b0, 1'b0);
`else
    en        = 1'b1;
    start     = 1'b1;
    burst_len = CW'(3);
    dir       = 1'b1;
    mode      = 3'b011;
    d         = 8'h5A;
    cyc("nb_load", 8'h5A, 1'b0, 1'b0);
    mode    = 3'b001;
    sr_inRS = 1'b0;
    cyc("nb_shr", 8'h2D, 1'b0, 1'b0);
    mode    = 3'b010;
    sr_inLS = 1'b1;
    cyc("nb_shl", 8'h5B, 1'b0, 1'b0);
    mode = 3'b000;
    for (int k = 0; k < 4; k++)
      cyc($sformatf("nb_hold%0d", k), 8'h5B, 1'b0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
